// File: rtl/clk_divider_multi.sv
// clk_divider_multi: independent programmable clock dividers with toggle/pulse modes and wrap-aligned reloads
module clk_divider_multi #(
  parameter int               NUM_CH      = 2,
  parameter int               CNT_W       = 32,
  parameter logic [CNT_W-1:0] DEFAULT_DIV = '0
) (
  input  logic                    clk_in,
  input  logic                    reset_n,
  input  logic [NUM_CH-1:0]       enable,
  input  logic [NUM_CH-1:0]       mode,
  input  logic [NUM_CH-1:0]       load,
  input  logic [NUM_CH*CNT_W-1:0] div_in,
  input  logic                    sync_restart,
  output logic [NUM_CH-1:0]       clk_out,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       pending
);
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [CNT_W-1:0] r_cnt, r_div, r_pdiv;
    logic             r_pend, r_mode, r_clk, r_tick;
    logic [CNT_W-1:0] w_din, w_next_div;
    logic             w_wrap;
    assign w_din      = div_in[g*CNT_W +: CNT_W];
    assign w_wrap     = r_cnt == r_div;
    // a same-cycle load wins over a queued value whenever the divider is applied
    assign w_next_div = load[g] ? w_din : (r_pend ? r_pdiv : r_div);
    // count, apply queued dividers only at wrap/restart/disable, and shape the output
    always_ff @(posedge clk_in or negedge reset_n)
      if (!reset_n) begin
        r_cnt  <= '0;
        r_div  <= DEFAULT_DIV;
        r_pdiv <= '0;
        r_pend <= 1'b0;
        r_mode <= 1'b0;
        r_clk  <= 1'b0;
        r_tick <= 1'b0;
      end else if (sync_restart || !enable[g]) begin
        r_cnt  <= '0;
        r_div  <= w_next_div;
        r_pend <= 1'b0;
        r_mode <= mode[g];
        r_clk  <= 1'b0;
        r_tick <= 1'b0;
      end else if (w_wrap) begin
        r_cnt  <= '0;
        r_div  <= w_next_div;
        r_pend <= 1'b0;
        r_mode <= mode[g];
        r_clk  <= mode[g] | ~r_clk;
        r_tick <= mode[g] | ~r_clk;
      end else begin
        r_cnt  <= r_cnt + 1'b1;
        r_clk  <= r_clk & ~r_mode;
        r_tick <= 1'b0;
        if (load[g]) begin
          r_pdiv <= w_din;
          r_pend <= 1'b1;
        end
      end
    assign clk_out[g] = r_clk;
    assign tick[g]    = r_tick;
    assign pending[g] = r_pend;
  end
endmodule
